cpu_sequencer: RTL

//   Multi-cycle instruction sequencer for the simple processor. Fetches an

---
 rtl/cpu_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle instruction sequencer owning pc and ir
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   work       run enable, sampled only in IDLE
//   imem_data  instruction read data, valid with imem_ack
//   imem_ack   instruction memory acknowledge
//   dmem_ack   data memory acknowledge
//   zero_flag  ALU zero flag, sampled in DECODE for JZ
//   pc         program counter / instruction fetch address
//   imem_req   instruction fetch request
//   ir         instruction register
//   alu_en     ALU execute strobe (one cycle)
//   reg_we     register-file write strobe (one cycle)
//   dmem_req   data memory request
//   dmem_we    data memory write qualifier, valid with dmem_req
//   halted     processor stopped by HALT
module cpu_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int OPC_W    = 4,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               work,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    input  logic               zero_flag,
    output logic [ADDR_W-1:0]  pc,
    output logic               imem_req,
    output logic [INSTR_W-1:0] ir,
    output logic               alu_en,
    output logic               reg_we,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] OP_ALU_LO = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ALU_HI = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_JZ     = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(15);

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_W-1:0]    pc_nxt;
    logic [INSTR_W-1:0]   ir_nxt;
    logic [OPC_W-1:0]     opc;
    logic [ADDR_W-1:0]    pc_inc;
    logic [ADDR_W-1:0]    target;

    assign opc    = ir[INSTR_W-1 -: OPC_W];
    // Natural ADDR_W-bit overflow gives the all-ones -> 0 wrap.
    assign pc_inc = pc + ADDR_W'(1);
    assign target = ir[ADDR_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pc / ir registers, loaded from the next-state logic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= ADDR_W'(RESET_PC);
            ir <= '0;
        end else begin
            pc <= pc_nxt;
            ir <= ir_nxt;
        end
    end

    // Next-state and pc/ir update
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            S_IDLE: begin
                if (work) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_nxt    = imem_data;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opc == OP_HALT) begin
                    state_nxt = S_HALT;
                end else if (opc >= OP_ALU_LO && opc <= OP_ALU_HI) begin
                    state_nxt = S_EXEC;
                end else if (opc == OP_LOAD || opc == OP_STORE) begin
                    state_nxt = S_MEM;
                end else if (opc == OP_JMP) begin
                    pc_nxt    = target;
                    state_nxt = S_IDLE;
                end else if (opc == OP_JZ) begin
                    pc_nxt    = zero_flag ? target : pc_inc;
                    state_nxt = S_IDLE;
                end else begin
                    // NOP and the unassigned opcodes C..E
                    pc_nxt    = pc_inc;
                    state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                state_nxt = S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (opc == OP_STORE) begin
                        pc_nxt    = pc_inc;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_nxt    = pc_inc;
                state_nxt = S_IDLE;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs; each strobe belongs to exactly one state, so at most
    // one of them can be active in any cycle.
    always_comb begin
        imem_req = 1'b0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = 1'b0;
        case (state)
            S_FETCH: imem_req = 1'b1;
            S_EXEC:  alu_en   = 1'b1;
            S_WB:    reg_we   = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc == OP_STORE);
            end
            S_HALT:  halted   = 1'b1;
            default: begin
            end
        endcase
    end

endmodule
